fnd_seg_reader: RTL

Read-back block for the multiplexed FND (7-segment) bus. It samples the segment lines and one-hot digit selects driven toward the display, and inverts the BCD-to-segment mapping back into 4-bit digit codes. It waits for each digit to be stable before accepting it, then assembles a full display frame and hands it to a consumer with a valid/ready handshake. It sits beside the FND driver and is used for self-check of the displayed temperature and for bench comparison.

---
 rtl/fnd_seg_reader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fnd_seg_reader.sv
// FND bus read-back: decodes stable one-hot digit samples back to BCD codes,
// assembles a full frame and offers it through a valid/ready handshake.
module fnd_seg_reader #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned STABLE_CNT = 3
) (
  input  logic                  iClk,
  input  logic                  iRsn,
  input  logic [6:0]            iSeg,
  input  logic [DIGITS-1:0]     iDigSel,
  input  logic                  iReady,
  output logic [4*DIGITS-1:0]   oBcd,
  output logic                  oValid,
  output logic                  oErr,
  output logic                  oOverrun
);

  localparam int unsigned CW = $clog2(STABLE_CNT + 1);
  localparam int unsigned BW = 4 * DIGITS;

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_HELD} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DIGITS-1:0] sel_q;
  logic [6:0]        seg_q;
  logic [DIGITS-1:0] cap_q, cap_d;
  logic [BW-1:0]     slot_q, slot_d;
  logic [DIGITS-1:0] serr_q, serr_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              ovr_q, ovr_d;

  logic [3:0]        code_c;
  logic              bad_c;
  logic              onehot_c;
  logic              same_c;
  logic              full_c;
  logic              capture_c;

  // Inverse segment map; blank is a legal digit, anything unknown is flagged.
  always_comb begin
    code_c = 4'hE;
    bad_c  = 1'b0;
    case (iSeg)
      7'h7E:   code_c = 4'h0;
      7'h30:   code_c = 4'h1;
      7'h6D:   code_c = 4'h2;
      7'h79:   code_c = 4'h3;
      7'h33:   code_c = 4'h4;
      7'h5B:   code_c = 4'h5;
      7'h5F:   code_c = 4'h6;
      7'h72:   code_c = 4'h7;
      7'h7F:   code_c = 4'h8;
      7'h7B:   code_c = 4'h9;
      7'h00:   code_c = 4'hF;
      default: bad_c  = 1'b1;
    endcase
  end

  assign onehot_c = (iDigSel != '0) && ((iDigSel & (iDigSel - DIGITS'(1))) == '0);
  assign same_c   = (iDigSel == sel_q) && (iSeg == seg_q);
  assign full_c   = &cap_q;

  // Stability tracking, slot capture and frame hand-off.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_d     = cap_q;
    slot_d    = slot_q;
    serr_d    = serr_q;
    capture_c = 1'b0;
    bcd_d     = bcd_q;
    valid_d   = valid_q;
    err_d     = err_q;
    ovr_d     = 1'b0;

    if (!onehot_c) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (same_c && (state_q != S_IDLE)) begin
      if (state_q == S_TRACK) begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_d == CW'(STABLE_CNT)) begin
          state_d   = S_HELD;
          capture_c = 1'b1;
        end
      end
    end else begin
      state_d = S_TRACK;
      cnt_d   = CW'(1);
    end

    if (full_c) cap_d = '0;

    if (capture_c) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (iDigSel[i]) begin
          slot_d[4*i +: 4] = code_c;
          serr_d[i]        = bad_c;
          cap_d[i]         = 1'b1;
        end
      end
    end

    // A completed frame replaces the pending one only if it is being consumed.
    if (full_c) begin
      if (!valid_q || iReady) begin
        bcd_d   = slot_q;
        err_d   = |serr_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && iReady) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      seg_q   <= '0;
      cap_q   <= '0;
      slot_q  <= '0;
      serr_q  <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= iDigSel;
      seg_q   <= iSeg;
      cap_q   <= cap_d;
      slot_q  <= slot_d;
      serr_q  <= serr_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  assign oBcd     = bcd_q;
  assign oValid   = valid_q;
  assign oErr     = err_q;
  assign oOverrun = ovr_q;

endmodule
